// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-BRAM boot loader.
//   boot_state_e : loader state (HDR, LOAD, RUN, ERR)
//   WORD_STRB    : byte-enable pattern for a full 32-bit word write
//   BYTE_IDX_W   : width of the byte-within-word counter
package boot_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,    // collecting the 4-byte big-endian word count
        LOAD = 2'd1,    // collecting program bytes and writing words
        RUN  = 2'd2,    // core owns BRAM port A
        ERR  = 2'd3     // bad word count; wait for reload/rst
    } boot_state_e;

    localparam logic [3:0] WORD_STRB  = 4'b1111;
    localparam int         BYTE_IDX_W = 2;

endpackage

// File: rtl/boot_byte_packer.sv
// Packs a UART byte stream into big-endian 32-bit words.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : drop any partial word and restart at byte 0
//   rx_data      : incoming byte
//   rx_valid     : byte strobe (already gated by the caller)
//   word         : assembled word, valid only while word_valid is high
//   word_valid   : high in the cycle the 4th byte of a word is presented
// word/word_valid are combinational from the 4th byte so the caller can
// register its write on the same edge that samples that byte.
module boot_byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [23:0]           shift_q, shift_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d = '0;
        end else if (rx_valid) begin
            // Counter wraps 3 -> 0, so the next byte starts a new word.
            idx_d   = idx_q + 1'b1;
            shift_d = {shift_q[15:0], rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign word       = {shift_q, rx_data};
    assign word_valid = rx_valid && !clear && (idx_q == {BYTE_IDX_W{1'b1}});

endmodule

// File: rtl/boot_controller.sv
// Boot loader: streams a length-prefixed program from the UART into
// instruction BRAM port A, then hands the port to the core and releases
// the core from reset.
//   BASE_ADDR, DEPTH_WORDS : first program byte address, BRAM capacity
//   clk, rst               : clock, synchronous active-high reset
//   rx_data, rx_valid      : UART byte stream
//   reload                 : restart loading from any state
//   core_addr, core_en     : core fetch request (used only in RUN)
//   inst_addra/dina/wea/ena: BRAM port A
//   core_rst               : reset to core, low only in RUN
//   loading, done, err     : status (HDR/LOAD, RUN, ERR)
module boot_controller
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [31:0] DEPTH_WORDS = 32'd16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    input  logic [31:0] core_addr,
    input  logic        core_en,
    output logic [31:0] inst_addra,
    output logic [31:0] inst_dina,
    output logic [3:0]  inst_wea,
    output logic        inst_ena,
    output logic        core_rst,
    output logic        loading,
    output logic        done,
    output logic        err
);

    boot_state_e state_q, state_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] addra_q, addra_d;
    logic [31:0] dina_q, dina_d;
    logic [3:0]  wea_q, wea_d;
    logic        ena_q, ena_d;

    logic        accept;
    logic [31:0] word;
    logic        word_valid;

    // Bytes are consumed in HDR and in LOAD until the last word is written.
    // After the last write LOAD lingers one cycle (remaining==0) so the
    // write is still on the port; bytes in that cycle are not program data.
    assign accept = (state_q == HDR) || ((state_q == LOAD) && (remaining_q != 32'd0));

    boot_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid && accept),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_addr_d   = wr_addr_q;
        addra_d     = addra_q;
        dina_d      = dina_q;
        wea_d       = '0;
        ena_d       = 1'b0;
        if (reload) begin
            state_d   = HDR;
            wr_addr_d = BASE_ADDR;
        end else begin
            unique case (state_q)
                HDR: begin
                    if (word_valid) begin
                        if ((word == 32'd0) || (word > DEPTH_WORDS)) begin
                            state_d = ERR;
                        end else begin
                            state_d     = LOAD;
                            remaining_d = word;
                            wr_addr_d   = BASE_ADDR;
                        end
                    end
                end
                LOAD: begin
                    if (remaining_q == 32'd0) begin
                        state_d = RUN;
                    end else if (word_valid) begin
                        addra_d     = wr_addr_q;
                        dina_d      = word;
                        wea_d       = WORD_STRB;
                        ena_d       = 1'b1;
                        wr_addr_d   = wr_addr_q + 32'd4;
                        remaining_d = remaining_q - 32'd1;
                    end
                end
                RUN, ERR: begin
                end
                default: state_d = HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            remaining_q <= '0;
            wr_addr_q   <= BASE_ADDR;
            addra_q     <= '0;
            dina_q      <= '0;
            wea_q       <= '0;
            ena_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_addr_q   <= wr_addr_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            wea_q       <= wea_d;
            ena_q       <= ena_d;
        end
    end

    // Port A: combinational pass-through from the core in RUN, registered
    // loader values otherwise.
    always_comb begin
        inst_addra = addra_q;
        inst_dina  = dina_q;
        inst_wea   = wea_q;
        inst_ena   = ena_q;
        if (state_q == RUN) begin
            inst_addra = core_addr;
            inst_dina  = '0;
            inst_wea   = '0;
            inst_ena   = core_en;
        end
    end

    assign core_rst = (state_q != RUN);
    assign loading  = (state_q == HDR) || (state_q == LOAD);
    assign done     = (state_q == RUN);
    assign err      = (state_q == ERR);

endmodule

// File: tb/tb_boot_controller.sv
module tb_boot_controller;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] DEPTH = 32'd64;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic [31:0] core_addr;
    logic        core_en;
    logic [31:0] inst_addra;
    logic [31:0] inst_dina;
    logic [3:0]  inst_wea;
    logic        inst_ena;
    logic        core_rst;
    logic        loading;
    logic        done;
    logic        err;

    boot_controller #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .reload     (reload),
        .core_addr  (core_addr),
        .core_en    (core_en),
        .inst_addra (inst_addra),
        .inst_dina  (inst_dina),
        .inst_wea   (inst_wea),
        .inst_ena   (inst_ena),
        .core_rst   (core_rst),
        .loading    (loading),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] last_addr  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the port shows a write, it must match the
    // oldest expected write, and last exactly one cycle.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (inst_wea !== 4'b0000) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                         inst_addra, inst_dina);
            end else begin
                e = sb.pop_front();
                check("wr_addr", inst_addra, e.addr);
                check("wr_data", inst_dina, e.data);
                check("wr_wea", {28'd0, inst_wea}, 32'hF);
                check("wr_ena", {31'd0, inst_ena}, 32'd1);
            end
            last_addr = inst_addra;
            $display("write addr 0x%08h data 0x%08h", inst_addra, inst_dina);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Sends one big-endian word; if a write is expected, the scoreboard
    // entry is queued just before the byte that completes it.
    task automatic send_word(input logic [31:0] w, input logic [31:0] addr,
                             input bit expect_wr, input int gapmax);
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
            if (k == 3 && expect_wr) begin
                e.addr = addr;
                e.data = w;
                sb.push_back(e);
            end
            send_byte(w[31 - 8*k -: 8]);
        end
    endtask

    // Reference model: a count in 1..DEPTH produces exactly count writes,
    // word i landing at BASE + 4*i; any other count produces none.
    task automatic run_load(input logic [31:0] count, input int nwords, input int gapmax);
        bit valid;
        valid = (count != 0) && (count <= DEPTH);
        send_word(count, 32'd0, 1'b0, gapmax);
        for (int i = 0; i < nwords; i++)
            send_word($urandom, BASE + 32'(4 * i), valid && (i < int'(count)), gapmax);
        $display("load count=%0d words=%0d", count, nwords);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addra"}, inst_addra, 32'd0);
        check({tag, "_dina"}, inst_dina, 32'd0);
        check({tag, "_wea"}, {28'd0, inst_wea}, 32'd0);
        check({tag, "_ena"}, {31'd0, inst_ena}, 32'd0);
        check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        check({tag, "_loading"}, {31'd0, loading}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        reload    = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
        core_addr = 32'd0;
        core_en   = 1'b0;
        idle(3);
        check_reset_values("reset");
        rst = 1'b0;
        idle(1);

        // Directed two-word load with random gaps.
        send_word(32'd2, 32'd0, 1'b0, 2);
        send_word(32'h1122_3344, BASE, 1'b1, 2);
        send_word(32'hAABB_CCDD, BASE + 32'd4, 1'b1, 2);
        check("done_in_last_write", {31'd0, done}, 32'd0);
        check("core_rst_in_last_write", {31'd0, core_rst}, 32'd1);
        idle(1);
        check("done_after_load", {31'd0, done}, 32'd1);
        check("core_rst_after_load", {31'd0, core_rst}, 32'd0);
        check("loading_after_load", {31'd0, loading}, 32'd0);
        $display("txn directed load of 2 words");

        // RUN: port A follows the core combinationally.
        #1;
        core_addr = 32'h40;
        core_en   = 1'b1;
        #1;
        check("run_addra", inst_addra, 32'h40);
        check("run_ena", {31'd0, inst_ena}, 32'd1);
        check("run_wea", {28'd0, inst_wea}, 32'd0);
        check("run_dina", inst_dina, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        check("run_done_after_rx", {31'd0, done}, 32'd1);
        $display("txn RUN mux and ignored rx");

        // Reload from RUN; core_en held high must not reach the port.
        pulse_reload();
        check("reload_loading", {31'd0, loading}, 32'd1);
        check("reload_core_rst", {31'd0, core_rst}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_ena_ignores_core", {31'd0, inst_ena}, 32'd0);
        core_en = 1'b0;

        // Zero count -> ERR, bytes ignored, reload recovers.
        send_word(32'd0, 32'd0, 1'b0, 1);
        check("zero_err", {31'd0, err}, 32'd1);
        check("zero_core_rst", {31'd0, core_rst}, 32'd1);
        check("zero_loading", {31'd0, loading}, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        check("zero_err_holds", {31'd0, err}, 32'd1);
        pulse_reload();
        check("err_reload_loading", {31'd0, loading}, 32'd1);
        check("err_reload_err", {31'd0, err}, 32'd0);
        $display("txn zero count");

        // Oversized count -> ERR with no writes.
        run_load(DEPTH + 32'd1, 2, 1);
        check("over_err", {31'd0, err}, 32'd1);
        pulse_reload();

        // Exactly DEPTH words back to back.
        run_load(DEPTH, int'(DEPTH), 0);
        idle(1);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_last_addr", last_addr, BASE + 32'd4 * (DEPTH - 32'd1));
        pulse_reload();

        // Count 2 with 8 back-to-back program bytes.
        run_load(32'd2, 2, 0);
        idle(1);
        check("b2b_done", {31'd0, done}, 32'd1);
        pulse_reload();

        // Partial header, then reload colliding with a byte that must drop.
        send_byte(8'h00);
        send_byte(8'h00);
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
        rx_valid = 1'b0;
        run_load(32'd1, 1, 1);
        idle(1);
        check("collide_done", {31'd0, done}, 32'd1);
        pulse_reload();

        // Reset mid-load discards the partial word.
        send_word(32'd2, 32'd0, 1'b0, 0);
        send_byte(8'h5A);
        send_byte(8'hA5);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        run_load(32'd1, 1, 2);
        idle(1);
        check("after_rst_done", {31'd0, done}, 32'd1);
        $display("txn reset mid-load");

        // Randomized loads.
        for (int r = 0; r < 4; r++) begin
            pulse_reload();
            run_load(32'($urandom_range(1, 5)), 0, 0);
        end
        // The loop above only sent headers; finish the last one properly.
        pulse_reload();
        for (int r = 0; r < 4; r++) begin
            logic [31:0] c;
            c = 32'($urandom_range(1, 5));
            run_load(c, int'(c), 2);
            idle(1);
            check("rand_done", {31'd0, done}, 32'd1);
            pulse_reload();
        end

        idle(2);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/boot_controller.md
# boot_controller

Sequences instruction-BRAM port A between program load and core execution. After reset it takes a UART byte stream (4-byte big-endian word count, then program bytes), packs bytes into 32-bit words, and writes each word to instruction BRAM with a full-word strobe. Once the last word is written it hands port A to the core's fetch path and releases the core from reset. It sits between the UART receiver, the core's fetch port and the instruction BRAM.

## Interface
- BASE_ADDR, 32'h0: byte address of the first program word
- DEPTH_WORDS, 16384: BRAM capacity in words; larger counts are rejected

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; may assert on consecutive cycles
- reload  in  1  one-cycle pulse, restart loading from any state
- core_addr  in  32  core fetch byte address
- core_en  in  1  core fetch enable
- inst_addra  out  32  BRAM port A address
- inst_dina  out  32  BRAM port A write data
- inst_wea  out  4  BRAM port A byte write enables
- inst_ena  out  1  BRAM port A enable
- core_rst  out  1  active-high reset to core
- loading  out  1  high in HDR/LOAD
- done  out  1  high in RUN
- err  out  1  high in ERR

## Operation
- States: HDR (collect 4 count bytes), LOAD (collect program bytes), RUN (core owns port), ERR.
- Byte packing: byte index 0..3 goes to [31:24], [23:16], [15:8], [7:0]. A 2-bit counter wraps 3->0.
- HDR: after the 4th byte, count = the packed word.
  - count==0 or count>DEPTH_WORDS -> ERR.
  - otherwise -> LOAD with remaining=count and wr_addr=BASE_ADDR.
- LOAD: on the 4th byte of each word, register a write: inst_dina=word, inst_addra=wr_addr, inst_wea=4'b1111, inst_ena=1 for exactly one cycle. Then wr_addr+=4 and remaining-=1.
- When remaining reaches 0 on a write -> RUN.
- In HDR, LOAD and ERR, port A outputs are registered loader values. When not writing: inst_wea=0, inst_ena=0.
- RUN: port A is combinational from the core: inst_addra=core_addr, inst_ena=core_en, inst_wea=0, inst_dina=0. rx_valid is ignored.
- ERR: core_rst=1 and err=1. rx_valid is ignored. Only reload or rst exits.
- reload in any state -> HDR:
  - byte counter=0, wr_addr=BASE_ADDR, core_rst=1 on the next cycle.
  - reload wins over a simultaneous rx_valid; that byte is dropped.
- Reset mid-load: any partial word is discarded and no write is issued.

## Timing
- Reset values: inst_addra=0, inst_dina=0, inst_wea=0, inst_ena=0, core_rst=1, loading=1, done=0, err=0, state=HDR.
- Write latency: 4th byte sampled at edge t -> write visible t..t+1 (one cycle).
- A byte arriving in the write cycle is accepted as byte 0 of the next word. No byte is ever lost in HDR/LOAD.
- Final write at cycle t. Port A switches to the core mux at t+1, with done=1 and core_rst=0 at t+1.
- The core must not fetch before done=1; core_en is ignored before RUN.
- Arithmetic: remaining is 32-bit unsigned. wr_addr wraps mod 2^32, which is unreachable given the DEPTH_WORDS check.

## Structure
- Package boot_pkg: state enum (HDR, LOAD, RUN, ERR), WORD_STRB=4'b1111, BYTE_IDX_W=2.
- Sub-module boot_byte_packer: takes rx_data/rx_valid/clear and emits a 32-bit word plus a one-cycle word_valid. It is reused for both the header and program words.
- boot_controller contains the FSM, address/count registers and the port-A output mux.

## Test plan
- Header 00 00 00 02, then bytes 11 22 33 44 AA BB CC DD:
  - writes 0x11223344 @0 and 0xAABBCCDD @4, each with wea=F for 1 cycle;
  - done=1 and core_rst=0 the cycle after the second write.
- Header 00 00 00 00 -> err=1, core_rst stays 1, no BRAM write. A reload pulse then returns to loading=1.
- Header count DEPTH_WORDS+1 -> ERR, zero writes. Count exactly DEPTH_WORDS is accepted; the last write goes to BASE_ADDR+4*(DEPTH_WORDS-1).
- Back-to-back rx_valid for 8 consecutive cycles after the header (count=2) -> both words written correctly, none dropped.
- rst asserted after 2 program bytes -> all outputs at reset values next cycle. A fresh load of 1 word writes @BASE_ADDR.
- In RUN, core_addr=0x40 with core_en=1 -> inst_addra=0x40, inst_ena=1, wea=0 in the same cycle. rx bytes in RUN cause no write.
